eva_epoch_ctr: RTL and testbench

Multi-channel, programmable-period access counter for the EVA replacement logic. Each channel counts qualifying cache accesses and closes an epoch after `period` of them. Completed epochs are queued per channel and presented one at a time, round-robin, to the shared EVA update engine over a valid/ready handshake. It replaces the single fixed-period, single-channel counter: no update request is lost while the engine is busy, and queue overflow is reported.

---
 rtl/eva_pkg.sv | 13 +
 rtl/eva_ch_ctr.sv | 40 ++++
 rtl/eva_epoch_ctr.sv | 86 ++++++++
 tb/tb_eva_epoch_ctr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/eva_pkg.sv
// eva_pkg: shared count_mode encodings and default sizing for the EVA epoch counter.
package eva_pkg;
    typedef enum logic [1:0] {
        CM_RD   = 2'b00,
        CM_WR   = 2'b01,
        CM_BOTH = 2'b10,
        CM_OFF  = 2'b11
    } count_mode_e;

    localparam int NUM_CH_DEF = 4;
    localparam int CTR_W_DEF  = 13;
    localparam int PEND_W_DEF = 3;
endpackage

// File: rtl/eva_ch_ctr.sv
// eva_ch_ctr: one channel's access counter, pending-epoch counter and sticky overflow flag.
module eva_ch_ctr #(
    parameter int CTR_W  = 13,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              qual,
    input  logic [CTR_W-1:0]  period,
    input  logic              accept,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);
    logic [CTR_W-1:0] cnt;
    logic             close;

    // >= rather than == so a period lowered mid-epoch still closes promptly
    assign close = qual && cnt >= period - CTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            pend     <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            if (qual) cnt <= close ? '0 : cnt + CTR_W'(1);
            if (close && !accept) begin
                if (&pend) overflow <= 1'b1;
                else pend <= pend + PEND_W'(1);
            end else if (accept && !close) begin
                pend <= pend - PEND_W'(1);
            end
        end
    end
endmodule

// File: rtl/eva_epoch_ctr.sv
// eva_epoch_ctr: multi-channel epoch counter with a locked round-robin offer to the EVA update engine.
module eva_epoch_ctr
    import eva_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CTR_W  = CTR_W_DEF,
    parameter int PEND_W = PEND_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        acc_valid,
    input  logic [NUM_CH-1:0]        acc_wr,
    input  logic [1:0]               count_mode,
    input  logic [CTR_W-1:0]         period,
    output logic                     upd_valid,
    output logic [CH_W-1:0]          upd_ch,
    input  logic                     upd_ready,
    output logic [NUM_CH*PEND_W-1:0] pend_cnt,
    output logic [NUM_CH-1:0]        overflow
);
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] pend_nz;
    logic [NUM_CH-1:0] accept;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   lk_ch;
    logic [CH_W-1:0]   sel;
    logic              lock;
    logic              found;
    int                j;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign qual[i] = acc_valid[i] && period != '0 &&
                         (count_mode == CM_BOTH ||
                          (count_mode == CM_RD && !acc_wr[i]) ||
                          (count_mode == CM_WR && acc_wr[i]));
        assign accept[i]  = upd_valid && upd_ready && upd_ch == CH_W'(i);
        assign pend_nz[i] = |pend_cnt[i*PEND_W +: PEND_W];
        eva_ch_ctr #(.CTR_W(CTR_W), .PEND_W(PEND_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .qual     (qual[i]),
            .period   (period),
            .accept   (accept[i]),
            .pend     (pend_cnt[i*PEND_W +: PEND_W]),
            .overflow (overflow[i])
        );
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && pend_nz[j[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = j[CH_W-1:0];
            end
        end
    end

    assign upd_valid = |pend_nz;
    // a stalled offer stays pinned to its channel until the engine takes it
    assign upd_ch    = lock ? lk_ch : sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            lk_ch  <= '0;
            lock   <= 1'b0;
        end else if (clear) begin
            rr_ptr <= '0;
            lk_ch  <= '0;
            lock   <= 1'b0;
        end else begin
            lock  <= upd_valid && !upd_ready;
            lk_ch <= upd_ch;
            if (upd_valid && upd_ready)
                rr_ptr <= (upd_ch == CH_W'(NUM_CH - 1)) ? '0 : upd_ch + CH_W'(1);
        end
    end
endmodule

// File: tb/tb_eva_epoch_ctr.sv
// tb_eva_epoch_ctr: directed bench with an accept scoreboard for eva_epoch_ctr.
module tb_eva_epoch_ctr;
    import eva_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  acc_valid = '0;
    logic [3:0]  acc_wr = '0;
    logic [1:0]  count_mode = CM_RD;
    logic [12:0] period = '0;
    logic        upd_valid;
    logic [1:0]  upd_ch;
    logic        upd_ready = 1'b0;
    logic [11:0] pend_cnt;
    logic [3:0]  overflow;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];

    eva_epoch_ctr dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .acc_valid  (acc_valid),
        .acc_wr     (acc_wr),
        .count_mode (count_mode),
        .period     (period),
        .upd_valid  (upd_valid),
        .upd_ch     (upd_ch),
        .upd_ready  (upd_ready),
        .pend_cnt   (pend_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pend_of(input int ch);
        return pend_cnt[ch*3 +: 3];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [3:0] m, input logic wr, input int n);
        acc_valid = m;
        acc_wr    = wr ? m : 4'b0;
        repeat (n) cyc();
        acc_valid = '0;
        acc_wr    = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic take(input int n);
        upd_ready = 1'b1;
        repeat (n) cyc();
        upd_ready = 1'b0;
    endtask

    // handshakes are judged just before the edge that completes them
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            if (exp_q.size() == 0) check("acc_unexpected", 32'(exp_q.size()), 32'd1);
            else check("acc_ch", 32'(upd_ch), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(upd_valid), 0);
        check("rst_ch", 32'(upd_ch), 0);
        check("rst_pend", 32'(pend_cnt), 0);
        check("rst_ovf", 32'(overflow), 0);

        period = 13'd4; count_mode = CM_RD;
        acc(4'b0001, 1'b0, 3);
        check("p4_3rd_valid", 32'(upd_valid), 0);
        acc(4'b0001, 1'b0, 1);
        check("p4_4th_valid", 32'(upd_valid), 1);
        check("p4_4th_ch", 32'(upd_ch), 0);
        check("p4_4th_pend", 32'(pend_of(0)), 1);
        acc(4'b0001, 1'b1, 3);
        check("p4_wr_pend", 32'(pend_of(0)), 1);
        exp_q.push_back(0);
        take(1);
        check("p4_acc_pend", 32'(pend_of(0)), 0);
        check("p4_acc_valid", 32'(upd_valid), 0);

        period = 13'd2; count_mode = CM_WR;
        acc(4'b0001, 1'b1, 2);
        check("mode_wr", 32'(pend_of(0)), 1);
        count_mode = CM_BOTH;
        acc(4'b0001, 1'b0, 1);
        acc(4'b0001, 1'b1, 1);
        check("mode_both", 32'(pend_of(0)), 2);
        count_mode = CM_OFF;
        acc(4'b0001, 1'b0, 4);
        check("mode_off", 32'(pend_of(0)), 2);
        count_mode = CM_RD; period = '0;
        acc(4'b0001, 1'b0, 4);
        check("period0", 32'(pend_of(0)), 2);
        do_clear();
        check("clr_pend", 32'(pend_cnt), 0);

        period = 13'd4;
        acc(4'b0001, 1'b0, 3);
        period = 13'd2;
        acc(4'b0001, 1'b0, 1);
        check("period_lower", 32'(pend_of(0)), 1);
        do_clear();

        period = 13'd4;
        acc(4'b1010, 1'b0, 4);
        check("rr_ch_first", 32'(upd_ch), 1);
        exp_q.push_back(1);
        exp_q.push_back(3);
        take(2);
        check("rr_valid_after", 32'(upd_valid), 0);
        check("rr_ptr_after", 32'(dut.rr_ptr), 0);
        do_clear();

        acc(4'b0100, 1'b0, 4);
        check("lock_ch2", 32'(upd_ch), 2);
        acc(4'b0001, 1'b0, 4);
        check("lock_hold", 32'(upd_ch), 2);
        check("lock_pend0", 32'(pend_of(0)), 1);
        exp_q.push_back(2);
        take(1);
        check("lock_next", 32'(upd_ch), 0);
        exp_q.push_back(0);
        take(1);
        check("lock_done", 32'(upd_valid), 0);
        do_clear();

        period = 13'd1;
        acc(4'b0001, 1'b0, 8);
        check("sat_pend", 32'(pend_of(0)), 7);
        check("sat_ovf", 32'(overflow), 1);
        exp_q.push_back(0);
        acc_valid = 4'b0001;
        take(1);
        acc_valid = '0;
        check("sat_acc_pend", 32'(pend_of(0)), 7);
        check("sat_acc_ovf", 32'(overflow), 1);
        do_clear();
        check("sat_clr_ovf", 32'(overflow), 0);

        acc(4'b0001, 1'b0, 1);
        check("sim_pre", 32'(pend_of(0)), 1);
        exp_q.push_back(0);
        acc_valid = 4'b0001;
        take(1);
        acc_valid = '0;
        check("sim_pend", 32'(pend_of(0)), 1);
        check("sim_valid", 32'(upd_valid), 1);
        exp_q.push_back(0);
        take(1);
        check("sim_drain", 32'(pend_of(0)), 0);
        do_clear();

        period = 13'd4;
        acc(4'b0001, 1'b0, 11);
        check("arst_pre", 32'(pend_of(0)), 2);
        rst = 1'b1;
        #2;
        check("arst_valid", 32'(upd_valid), 0);
        check("arst_pend", 32'(pend_cnt), 0);
        check("arst_ch", 32'(upd_ch), 0);
        rst = 1'b0;
        cyc();
        acc(4'b0001, 1'b0, 3);
        check("arst_cnt0", 32'(upd_valid), 0);
        acc(4'b0001, 1'b0, 1);
        check("arst_cnt4", 32'(pend_of(0)), 1);
        do_clear();

        acc(4'b0001, 1'b0, 3);
        acc_valid = 4'b0001;
        do_clear();
        acc_valid = '0;
        check("clr_close_pend", 32'(pend_of(0)), 0);
        acc(4'b0001, 1'b0, 3);
        check("clr_cnt0", 32'(upd_valid), 0);
        acc(4'b0001, 1'b0, 1);
        check("clr_cnt4", 32'(pend_of(0)), 1);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
